// File: rtl/peaks_readout_if.sv
// Host register bus for peaks_readout: byte-addressed writes, registered read data.
interface peaks_readout_if;
    logic       chipselect;
    logic       write;
    logic [7:0] address;
    logic [7:0] writedata;
    logic [7:0] readdata;

    modport master (output chipselect, write, address, writedata, input readdata);
    modport slave  (input chipselect, write, address, writedata, output readdata);
endinterface

// File: rtl/peaks_readout.sv
// Double-buffered peak-frame readout: captures frames into a fill bank while the host
// reads a stable host bank; a lock write swaps banks when a fresh frame is available.
module peaks_readout #(
    parameter int PEAKS      = 6,
    parameter int FREQ_WIDTH = 8,
    parameter int AMPL_WIDTH = 32,
    parameter int TIME_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        valid_in,
    input  logic [TIME_WIDTH-1:0]       counter_in,
    input  logic [PEAKS*FREQ_WIDTH-1:0] freqs_in,
    input  logic [PEAKS*AMPL_WIDTH-1:0] ampls_in,
    peaks_readout_if.slave              host
);
    localparam int TIME_BYTES = TIME_WIDTH / 8;
    localparam int FREQ_BYTES = FREQ_WIDTH / 8;
    localparam int AMPL_BYTES = AMPL_WIDTH / 8;
    localparam int FREQ_BASE  = TIME_BYTES;
    localparam int AMPL_BASE  = FREQ_BASE + PEAKS * FREQ_BYTES;
    localparam int BANK_BYTES = AMPL_BASE + PEAKS * AMPL_BYTES;
    localparam int IDX_W      = $clog2(BANK_BYTES);

    localparam logic [7:0] ADDR_CTRL   = 8'hF0;
    localparam logic [7:0] ADDR_STATUS = 8'hF1;
    localparam logic [7:0] ADDR_DROPS  = 8'hF2;

    typedef enum logic {UNLOCKED, LOCKED} state_t;
    typedef logic [7:0] bank_t [BANK_BYTES];

    state_t           state_q, state_d;
    bank_t            bank_a, bank_b, frame;
    logic             hsel, new_frame, swap;
    logic [7:0]       drops, rd_d;
    logic             host_wr, ctrl_wr, drops_clr;
    logic [IDX_W-1:0] rd_idx;
    logic             unused_wdata;

    assign host_wr      = host.chipselect & host.write;
    assign ctrl_wr      = host_wr && (host.address == ADDR_CTRL);
    assign drops_clr    = host_wr && (host.address == ADDR_DROPS);
    assign rd_idx       = host.address[IDX_W-1:0];
    assign unused_wdata = ^host.writedata[7:1];

    // Byte image of the incoming frame; multi-byte fields are stored MSB first.
    always_comb begin
        frame = '{default: '0};
        for (int b = 0; b < TIME_BYTES; b++)
            frame[b] = counter_in[(TIME_BYTES-1-b)*8 +: 8];
        for (int p = 0; p < PEAKS; p++)
            for (int b = 0; b < FREQ_BYTES; b++)
                frame[FREQ_BASE + p*FREQ_BYTES + b] = freqs_in[p*FREQ_WIDTH + (FREQ_BYTES-1-b)*8 +: 8];
        for (int p = 0; p < PEAKS; p++)
            for (int b = 0; b < AMPL_BYTES; b++)
                frame[AMPL_BASE + p*AMPL_BYTES + b] = ampls_in[p*AMPL_WIDTH + (AMPL_BYTES-1-b)*8 +: 8];
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) state_q <= UNLOCKED;
        else       state_q <= state_d;
    end

    always_comb begin
        // NOTE: defaults first so no path through this block leaves an output unassigned (no latches).
        state_d = state_q;
        swap    = 1'b0;
        if (ctrl_wr) begin
            if (host.writedata[0]) begin
                state_d = LOCKED;
                swap    = new_frame | valid_in;
            end else begin
                state_d = UNLOCKED;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the banks are flops and are cleared, so a reset while locked cannot expose a stale frame.
            bank_a    <= '{default: '0};
            bank_b    <= '{default: '0};
            hsel      <= 1'b0;
            new_frame <= 1'b0;
            drops     <= 8'h00;
        end else begin
            // The fill bank is always the one the host is not looking at.
            if (valid_in) begin
                if (hsel) bank_a <= frame;
                else      bank_b <= frame;
            end
            if (swap) begin
                hsel      <= ~hsel;
                new_frame <= 1'b0;
            end else if (valid_in) begin
                new_frame <= 1'b1;
            end
            if (drops_clr)
                drops <= 8'h00;
            else if (valid_in && new_frame && drops != 8'hFF)
                drops <= drops + 8'd1;
        end
    end

    always_comb begin
        rd_d = 8'h00;
        if (host.address < 8'(BANK_BYTES)) begin
            rd_d = hsel ? bank_b[rd_idx] : bank_a[rd_idx];
        end else begin
            case (host.address)
                ADDR_CTRL:   rd_d = {7'b0, state_q == LOCKED};
                ADDR_STATUS: rd_d = {6'b0, hsel, new_frame};
                ADDR_DROPS:  rd_d = drops;
                8'hF8:       rd_d = 8'd42;
                8'hF9:       rd_d = 8'd53;
                8'hFA:       rd_d = 8'd84;
                8'hFB:       rd_d = 8'd71;
                8'hFC:       rd_d = 8'd7;
                8'hFD:       rd_d = 8'd25;
                8'hFE:       rd_d = 8'd48;
                8'hFF:       rd_d = 8'd96;
                default:     rd_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) host.readdata <= 8'h00;
        else       host.readdata <= rd_d;
    end
endmodule

// File: tb/tb_peaks_readout.sv
// Randomized scoreboard bench for peaks_readout: a frame-level model predicts every host
// read; a negedge monitor pops and compares the registered read data.
`timescale 1ns/1ps
module tb_peaks_readout;
    localparam int PEAKS = 6;
    localparam int FW    = 8;
    localparam int AW    = 32;
    localparam int TW    = 32;

    logic                clk = 1'b0;
    logic                reset;
    logic                valid_in;
    logic [TW-1:0]       counter_in;
    logic [PEAKS*FW-1:0] freqs_in;
    logic [PEAKS*AW-1:0] ampls_in;

    peaks_readout_if host ();

    peaks_readout #(.PEAKS(PEAKS), .FREQ_WIDTH(FW), .AMPL_WIDTH(AW), .TIME_WIDTH(TW)) dut (
        .clk        (clk),
        .reset      (reset),
        .valid_in   (valid_in),
        .counter_in (counter_in),
        .freqs_in   (freqs_in),
        .ampls_in   (ampls_in),
        .host       (host)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [TW-1:0]             ctr;
        logic [PEAKS-1:0][FW-1:0]  fr;
        logic [PEAKS-1:0][AW-1:0]  am;
    } frame_t;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    frame_t     m_bank [2];
    logic       m_hsel, m_new, m_locked;
    int         m_drops;
    logic [7:0] id_bytes [8] = '{8'd42, 8'd53, 8'd84, 8'd71, 8'd7, 8'd25, 8'd48, 8'd96};

    int   n_checks = 0;
    int   n_errors = 0;
    logic rd_pend = 1'b0;
    bit   drain_req = 1'b0;
    bit   drain_done = 1'b0;

    // Reference model: what the host should see, computed from the frame fields.
    function automatic logic [7:0] model_read(input logic [7:0] a);
        frame_t f;
        int     ai;
        f  = m_bank[m_hsel];
        ai = int'(a);
        if (ai < 4)   return f.ctr[8*(3-ai) +: 8];
        if (ai < 10)  return f.fr[ai-4];
        if (ai < 34)  return f.am[(ai-10)/4][8*(3-((ai-10)%4)) +: 8];
        if (ai < 240) return 8'h00;
        if (ai == 240) return {7'b0, m_locked};
        if (ai == 241) return {6'b0, m_hsel, m_new};
        if (ai == 242) return 8'(m_drops);
        if (ai < 248) return 8'h00;
        return id_bytes[ai-248];
    endfunction

    task automatic model_update();
        bit     hw, lock, unlock, cap, swp;
        frame_t fin;
        if (reset) begin
            m_bank[0] = '0;
            m_bank[1] = '0;
            m_hsel    = 1'b0;
            m_new     = 1'b0;
            m_locked  = 1'b0;
            m_drops   = 0;
            return;
        end
        cap    = valid_in;
        hw     = host.chipselect && host.write;
        lock   = hw && host.address == 8'hF0 && host.writedata[0];
        unlock = hw && host.address == 8'hF0 && !host.writedata[0];
        swp    = lock && (m_new || cap);
        fin.ctr = counter_in;
        fin.fr  = freqs_in;
        fin.am  = ampls_in;
        if (cap) m_bank[!m_hsel] = fin;
        if (hw && host.address == 8'hF2) m_drops = 0;
        else if (cap && m_new && m_drops < 255) m_drops++;
        if (swp) begin
            m_hsel = !m_hsel;
            m_new  = 1'b0;
        end else if (cap) begin
            m_new = 1'b1;
        end
        if (lock) m_locked = 1'b1;
        else if (unlock) m_locked = 1'b0;
    endtask

    // One clock: queue the expectation for a read, advance the model, then cross the edge.
    task automatic step(input bit use_k = 1'b0, input logic [7:0] k = 8'h00);
        exp_t e;
        if (host.chipselect && !host.write) begin
            e.addr = host.address;
            if (use_k)      e.data = k;
            else if (reset) e.data = 8'h00;
            else            e.data = model_read(host.address);
            exp_q.push_back(e);
        end
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_bus(input logic cs, input logic wr, input logic [7:0] a, input logic [7:0] d);
        host.chipselect = cs;
        host.write      = wr;
        host.address    = a;
        host.writedata  = d;
    endtask

    task automatic rand_frame();
        counter_in = $urandom;
        for (int p = 0; p < PEAKS; p++) begin
            freqs_in[p*FW +: FW] = 8'($urandom);
            ampls_in[p*AW +: AW] = $urandom;
        end
    endtask

    task automatic capture(input logic [31:0] ctr, input logic [7:0] f0, input logic [31:0] a0);
        rand_frame();
        counter_in     = ctr;
        freqs_in[7:0]  = f0;
        ampls_in[31:0] = a0;
        valid_in       = 1'b1;
        set_bus(1'b0, 1'b0, 8'h00, 8'h00);
        step();
        valid_in = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        valid_in = 1'b0;
        set_bus(1'b1, 1'b1, a, d);
        step();
    endtask

    task automatic rdk(input logic [7:0] a, input logic [7:0] k);
        valid_in = 1'b0;
        set_bus(1'b1, 1'b0, a, 8'h00);
        step(1'b1, k);
    endtask

    // Monitor: a read issued on an edge is visible on readdata by the following negedge.
    always @(posedge clk) rd_pend <= host.chipselect && !host.write;

    always @(negedge clk) begin
        exp_t e;
        if (rd_pend) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL readdata: got %02h with no pending expectation", host.readdata);
            end else begin
                e = exp_q.pop_front();
                if (host.readdata !== e.data) begin
                    n_errors++;
                    $display("FAIL readdata[%02h]: got %02h expected %02h at %0t",
                             e.addr, host.readdata, e.data, $time);
                end
            end
        end
        if (drain_req && !drain_done) begin
            drain_done = 1'b1;
            n_checks++;
            if (exp_q.size() != 0) begin
                n_errors++;
                $display("FAIL drain: %0d expectations never answered, expected 0", exp_q.size());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int         op;
        logic [7:0] a;

        reset    = 1'b1;
        valid_in = 1'b0;
        rand_frame();
        set_bus(1'b0, 1'b0, 8'h00, 8'h00);
        step();
        step();
        rdk(8'hF8, 8'h00);          // readdata held at zero while in reset
        reset = 1'b0;

        // Reset state
        rdk(8'h00, 8'h00);
        rdk(8'hF0, 8'h00);
        rdk(8'hF1, 8'h00);
        rdk(8'hF2, 8'h00);
        rdk(8'hF8, 8'd42);

        // Capture then lock: frame appears in host bank
        capture(32'h12345678, 8'h2A, 32'hDEADBEEF);
        wr(8'hF0, 8'h01);
        rdk(8'd0,  8'h12);
        rdk(8'd1,  8'h34);
        rdk(8'd2,  8'h56);
        rdk(8'd3,  8'h78);
        rdk(8'd4,  8'h2A);
        rdk(8'd10, 8'hDE);
        rdk(8'd13, 8'hEF);
        rdk(8'hF1, 8'h02);
        rdk(8'hF0, 8'h01);

        // New capture while locked leaves host bank alone until relock
        capture(32'h00000099, 8'h00, 32'h0);
        rdk(8'd3,  8'h78);
        rdk(8'hF1, 8'h03);
        wr(8'hF0, 8'h01);
        rdk(8'd3,  8'h99);
        rdk(8'hF1, 8'h00);

        // Drop counter
        wr(8'hF2, 8'h00);
        repeat (3) capture($urandom, 8'($urandom), $urandom);
        rdk(8'hF2, 8'd2);
        wr(8'hF2, 8'h5A);
        rdk(8'hF2, 8'd0);
        repeat (300) capture($urandom, 8'($urandom), $urandom);
        rdk(8'hF2, 8'hFF);
        rand_frame();                // clear beats a same-cycle increment
        valid_in = 1'b1;
        set_bus(1'b1, 1'b1, 8'hF2, 8'h00);
        step();
        rdk(8'hF2, 8'h00);

        // Lock in the same cycle as a capture
        wr(8'hF0, 8'h01);
        rand_frame();
        counter_in = 32'hAABBCCDD;
        valid_in   = 1'b1;
        set_bus(1'b1, 1'b1, 8'hF0, 8'h01);
        step();
        rdk(8'd0,  8'hAA);
        rdk(8'd3,  8'hDD);
        rdk(8'hF1, 8'h00);
        rdk(8'hF2, 8'h00);
        rdk(8'hF0, 8'h01);

        // Reset while locked, overriding a same-cycle capture and lock write
        reset = 1'b1;
        rand_frame();
        valid_in = 1'b1;
        set_bus(1'b1, 1'b1, 8'hF0, 8'h01);
        step();
        reset = 1'b0;
        rdk(8'hF0, 8'h00);
        rdk(8'd0,  8'h00);
        rdk(8'hF8, 8'd42);
        rdk(8'hF1, 8'h00);
        rdk(8'd34, 8'h00);
        rdk(8'hEF, 8'h00);
        rdk(8'hF3, 8'h00);
        rdk(8'hFF, 8'd96);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rand_frame();
            valid_in = ($urandom_range(0, 3) == 0);
            reset    = ($urandom_range(0, 199) == 0);
            op       = int'($urandom_range(0, 99));
            if (op < 50) begin
                case ($urandom_range(0, 2))
                    0:       a = 8'($urandom_range(0, 33));
                    1:       a = 8'($urandom_range(240, 255));
                    default: a = 8'($urandom);
                endcase
                set_bus(1'b1, 1'b0, a, 8'($urandom));
            end else if (op < 62) begin
                set_bus(1'b1, 1'b1, 8'hF0, 8'($urandom));
            end else if (op < 67) begin
                set_bus(1'b1, 1'b1, 8'hF2, 8'($urandom));
            end else if (op < 75) begin
                a = 8'($urandom);
                if (a == 8'hF0 || a == 8'hF2) a = 8'hF1;
                set_bus(1'b1, 1'b1, a, 8'($urandom));
            end else begin
                set_bus(1'b0, 1'($urandom), 8'($urandom), 8'($urandom));
            end
            step();
        end
        reset    = 1'b0;
        valid_in = 1'b0;
        set_bus(1'b0, 1'b0, 8'h00, 8'h00);
        step();
        step();
        drain_req = 1'b1;
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
